// File: rtl/cpu_bus_supervisor.sv
// Halts or restarts the cpuv2 core and arbitrates its byte-wide RAM between the CPU and
// the serial monitor. Control outputs are registered; the memory mux follows the registered state.
module cpu_bus_supervisor #(
  parameter int unsigned addr_width   = 9,
  parameter int unsigned BOOT_ADDR    = 0,
  parameter int unsigned HALT_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  // CPU side
  input  logic [addr_width-1:0] cpu_raddr,
  input  logic [addr_width-1:0] cpu_waddr,
  input  logic                  cpu_write,
  input  logic [7:0]            cpu_wdata,
  output logic [7:0]            cpu_rdata,
  output logic                  cpu_reset,
  output logic                  cpu_halt,
  input  logic                  cpu_halted,
  output logic [addr_width-1:0] cpu_start_address,
  // monitor side
  input  logic                  mon_req,
  output logic                  mon_gnt,
  input  logic [addr_width-1:0] mon_raddr,
  input  logic [addr_width-1:0] mon_waddr,
  input  logic                  mon_write,
  input  logic [7:0]            mon_wdata,
  output logic [7:0]            mon_rdata,
  input  logic                  mon_run,
  input  logic [addr_width-1:0] mon_start_addr,
  // RAM side
  output logic [addr_width-1:0] mem_raddr,
  output logic [addr_width-1:0] mem_waddr,
  output logic                  mem_write,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  // status
  output logic                  cpu_stopped,
  output logic                  halt_timeout
);

  localparam int unsigned CntW = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(HALT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StStart,
    StRun,
    StHaltReq,
    StMon,
    StIdle
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [addr_width-1:0]   start_d;
  logic                    stopped_d;
  logic                    timeout_d;
  logic                    forced;
  logic                    cpu_reset_d;
  logic                    cpu_halt_d;
  logic                    mon_gnt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = cpu_start_address;
    stopped_d = cpu_stopped;
    timeout_d = halt_timeout;
    forced    = 1'b0;

    case (state_q)
      StStart: state_d = StRun;
      StRun: begin
        if (mon_req) begin
          state_d = StHaltReq;
          cnt_d   = '0;
        end else if (cpu_halted) begin
          state_d   = StIdle;
          stopped_d = 1'b1;
        end
      end
      // A dropped mon_req does not abort the halt; StMon then falls through to StIdle.
      StHaltReq: begin
        if (cpu_halted) begin
          state_d   = StMon;
          timeout_d = 1'b0;
        end else if (cnt_q == CntLast) begin
          state_d   = StMon;
          timeout_d = 1'b1;
          forced    = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StMon: begin
        if (mon_run) begin
          state_d = StStart;
          start_d = mon_start_addr;
        end else if (!mon_req) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (mon_run) begin
          state_d = StStart;
          start_d = mon_start_addr;
        end else if (mon_req) begin
          state_d = StMon;
        end
      end
      default: state_d = StStart;
    endcase

    if (state_d == StStart) begin
      stopped_d = 1'b0;
    end

    // A timed-out CPU is kept in reset until the next run command.
    case (state_d)
      StStart:        cpu_reset_d = 1'b1;
      StMon, StIdle:  cpu_reset_d = forced | cpu_reset;
      default:        cpu_reset_d = 1'b0;
    endcase

    cpu_halt_d = (state_d == StHaltReq) || (state_d == StMon) || (state_d == StIdle);
    mon_gnt_d  = (state_d == StMon);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StStart;
      cnt_q             <= '0;
      cpu_reset         <= 1'b1;
      cpu_halt          <= 1'b0;
      mon_gnt           <= 1'b0;
      cpu_start_address <= addr_width'(BOOT_ADDR);
      cpu_stopped       <= 1'b0;
      halt_timeout      <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      cpu_reset         <= cpu_reset_d;
      cpu_halt          <= cpu_halt_d;
      mon_gnt           <= mon_gnt_d;
      cpu_start_address <= start_d;
      cpu_stopped       <= stopped_d;
      halt_timeout      <= timeout_d;
    end
  end

  // In StIdle nobody owns the bus: addresses follow the CPU but writes are blocked.
  always_comb begin
    mem_raddr = cpu_raddr;
    mem_waddr = cpu_waddr;
    mem_wdata = cpu_wdata;
    mem_write = 1'b0;
    case (state_q)
      StStart, StRun, StHaltReq: mem_write = cpu_write;
      StMon: begin
        mem_raddr = mon_raddr;
        mem_waddr = mon_waddr;
        mem_wdata = mon_wdata;
        mem_write = mon_write;
      end
      default: mem_write = 1'b0;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign mon_rdata = mem_rdata;

endmodule

// File: tb/tb_cpu_bus_supervisor.sv
// Directed bench for cpu_bus_supervisor: stimulus queues timed expectations, a negedge
// monitor pops and checks them against the DUT and a behavioural RAM.
module tb_cpu_bus_supervisor;

  localparam int AW = 9;

  localparam int SReset   = 0;
  localparam int SHalt    = 1;
  localparam int SGnt     = 2;
  localparam int SAddr    = 3;
  localparam int SStopped = 4;
  localparam int STimeout = 5;
  localparam int SMemWr   = 6;
  localparam int SRam5    = 7;
  localparam int SRam10   = 8;
  localparam int SMemWa   = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] cpu_raddr, cpu_waddr;
  logic          cpu_write;
  logic [7:0]    cpu_wdata, cpu_rdata;
  logic          cpu_reset, cpu_halt, cpu_halted;
  logic [AW-1:0] cpu_start_address;
  logic          mon_req, mon_gnt;
  logic [AW-1:0] mon_raddr, mon_waddr;
  logic          mon_write;
  logic [7:0]    mon_wdata, mon_rdata;
  logic          mon_run;
  logic [AW-1:0] mon_start_addr;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic          mem_write;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;
  logic          cpu_stopped, halt_timeout;

  logic [7:0] ram [0:(1<<AW)-1];

  typedef struct {
    int          cyc;
    int          sig;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] act;

  cpu_bus_supervisor #(
    .addr_width  (AW),
    .BOOT_ADDR   (0),
    .HALT_TIMEOUT(16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .cpu_raddr        (cpu_raddr),
    .cpu_waddr        (cpu_waddr),
    .cpu_write        (cpu_write),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_reset        (cpu_reset),
    .cpu_halt         (cpu_halt),
    .cpu_halted       (cpu_halted),
    .cpu_start_address(cpu_start_address),
    .mon_req          (mon_req),
    .mon_gnt          (mon_gnt),
    .mon_raddr        (mon_raddr),
    .mon_waddr        (mon_waddr),
    .mon_write        (mon_write),
    .mon_wdata        (mon_wdata),
    .mon_rdata        (mon_rdata),
    .mon_run          (mon_run),
    .mon_start_addr   (mon_start_addr),
    .mem_raddr        (mem_raddr),
    .mem_waddr        (mem_waddr),
    .mem_write        (mem_write),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .cpu_stopped      (cpu_stopped),
    .halt_timeout     (halt_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  function automatic logic [15:0] get_sig(input int s);
    case (s)
      SReset:   return {15'd0, cpu_reset};
      SHalt:    return {15'd0, cpu_halt};
      SGnt:     return {15'd0, mon_gnt};
      SAddr:    return {7'd0, cpu_start_address};
      SStopped: return {15'd0, cpu_stopped};
      STimeout: return {15'd0, halt_timeout};
      SMemWr:   return {15'd0, mem_write};
      SRam5:    return {8'd0, ram[5]};
      SRam10:   return {8'd0, ram[16]};
      SMemWa:   return {7'd0, mem_waddr};
      default:  return 16'hdead;
    endcase
  endfunction

  task automatic expect_at(input int dc, input int sig, input logic [15:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + dc;
    e.sig  = sig;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: at each negedge, check every expectation due this cycle.
  initial forever begin
    @(negedge clk);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        n_checks = n_checks + 1;
        if (sb[i].cyc < cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: check due at cycle %0d not sampled (now %0d)",
                   sb[i].name, sb[i].cyc, cyc);
        end else begin
          act = get_sig(sb[i].sig);
          if (act !== sb[i].exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h",
                     sb[i].name, cyc, act, sb[i].exp);
          end
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b1;
    cpu_raddr = '0; cpu_waddr = '0; cpu_write = 1'b0; cpu_wdata = '0; cpu_halted = 1'b0;
    mon_req = 1'b0; mon_raddr = '0; mon_waddr = '0; mon_write = 1'b0; mon_wdata = '0;
    mon_run = 1'b0; mon_start_addr = '0;

    // Reset values, then one extra START cycle before RUN.
    tick(2);
    expect_at(0, SReset, 16'd1, "rst_cpu_reset");
    expect_at(0, SHalt, 16'd0, "rst_cpu_halt");
    expect_at(0, SGnt, 16'd0, "rst_mon_gnt");
    expect_at(0, SAddr, 16'h000, "rst_start_addr");
    expect_at(0, SStopped, 16'd0, "rst_stopped");
    expect_at(0, STimeout, 16'd0, "rst_timeout");
    reset = 1'b0;
    expect_at(0, SReset, 16'd1, "start_cpu_reset");
    expect_at(1, SReset, 16'd0, "run_cpu_reset");
    tick(1);
    cpu_write = 1'b1; cpu_waddr = 9'h005; cpu_wdata = 8'h3C;
    expect_at(0, SMemWr, 16'd1, "cpu_wr_strobe");
    expect_at(1, SRam5, 16'h3C, "cpu_wr_ram");
    tick(1);
    cpu_write = 1'b0;

    // Halt handshake; CPU acks 2 cycles after cpu_halt.
    mon_req = 1'b1;
    expect_at(1, SHalt, 16'd1, "hreq_halt");
    expect_at(1, SGnt, 16'd0, "hreq_gnt");
    tick(3);
    cpu_halted = 1'b1;
    expect_at(0, SGnt, 16'd0, "ack_gnt_low");
    expect_at(1, SGnt, 16'd1, "ack_gnt");
    expect_at(1, STimeout, 16'd0, "ack_timeout");
    expect_at(1, SReset, 16'd0, "ack_cpu_reset");
    tick(1);
    mon_write = 1'b1; mon_waddr = 9'h010; mon_wdata = 8'hA5;
    cpu_write = 1'b1; cpu_waddr = 9'h010; cpu_wdata = 8'hFF;
    expect_at(0, SMemWa, 16'h010, "mon_waddr_mux");
    expect_at(1, SRam10, 16'hA5, "mon_wr_ram");
    tick(1);
    mon_write = 1'b0; cpu_write = 1'b0;

    // Drop mon_req -> IDLE; re-request -> MON without handshake.
    mon_req = 1'b0;
    expect_at(1, SGnt, 16'd0, "idle_gnt");
    expect_at(1, SHalt, 16'd1, "idle_halt");
    expect_at(1, SReset, 16'd0, "idle_cpu_reset");
    tick(1);
    mon_req = 1'b1;
    expect_at(1, SGnt, 16'd1, "idle_to_mon_gnt");
    tick(1);

    // Run command from MON.
    mon_run = 1'b1; mon_start_addr = 9'h040; cpu_halted = 1'b0; mon_req = 1'b0;
    expect_at(1, SGnt, 16'd0, "run_gnt");
    expect_at(1, SReset, 16'd1, "run_start_reset");
    expect_at(1, SAddr, 16'h040, "run_start_addr");
    expect_at(2, SReset, 16'd0, "run_release");
    expect_at(2, SHalt, 16'd0, "run_halt");
    tick(1);
    mon_run = 1'b0; mon_start_addr = 9'h1FF;
    tick(1);

    // mon_run in RUN is ignored.
    mon_run = 1'b1; mon_start_addr = 9'h123;
    expect_at(1, SAddr, 16'h040, "ign_addr1");
    expect_at(2, SAddr, 16'h040, "ign_addr2");
    expect_at(1, SReset, 16'd0, "ign_reset");
    expect_at(1, SHalt, 16'd0, "ign_halt");
    tick(1);
    mon_run = 1'b0;

    // Halt timeout: CPU never acks.
    mon_req = 1'b1;
    expect_at(16, SGnt, 16'd0, "to_gnt_early");
    expect_at(16, SReset, 16'd0, "to_reset_early");
    expect_at(16, SHalt, 16'd1, "to_halt_hold");
    expect_at(17, SReset, 16'd1, "to_cpu_reset");
    expect_at(17, STimeout, 16'd1, "to_flag");
    expect_at(17, SGnt, 16'd1, "to_gnt");
    tick(17);

    // Timed-out CPU stays in reset through IDLE; run from IDLE.
    mon_req = 1'b0;
    expect_at(1, SGnt, 16'd0, "to_idle_gnt");
    expect_at(1, SReset, 16'd1, "to_idle_reset");
    expect_at(1, SHalt, 16'd1, "to_idle_halt");
    tick(1);
    mon_run = 1'b1; mon_start_addr = 9'h0AA;
    expect_at(1, SReset, 16'd1, "idle_run_reset");
    expect_at(1, SAddr, 16'h0AA, "idle_run_addr");
    expect_at(1, SHalt, 16'd0, "idle_run_halt");
    expect_at(2, SReset, 16'd0, "idle_run_release");
    expect_at(2, STimeout, 16'd1, "timeout_sticky");
    tick(1);
    mon_run = 1'b0;
    tick(1);

    // Spontaneous halt in RUN; monitor write in IDLE is blocked.
    cpu_halted = 1'b1;
    expect_at(1, SStopped, 16'd1, "stopped_set");
    expect_at(1, SHalt, 16'd1, "stopped_halt");
    expect_at(1, SGnt, 16'd0, "stopped_gnt");
    tick(1);
    mon_write = 1'b1; mon_waddr = 9'h010; mon_wdata = 8'h77; mon_req = 1'b1;
    expect_at(0, SMemWr, 16'd0, "idle_wr_blocked");
    expect_at(1, SGnt, 16'd1, "stopped_mon_gnt");
    expect_at(1, SRam10, 16'hA5, "idle_wr_ram");
    tick(1);
    mon_write = 1'b0;

    // Reset while in MON.
    reset = 1'b1; cpu_halted = 1'b0;
    expect_at(1, SGnt, 16'd0, "mrst_gnt");
    expect_at(1, SReset, 16'd1, "mrst_cpu_reset");
    expect_at(1, SHalt, 16'd0, "mrst_halt");
    expect_at(1, SStopped, 16'd0, "mrst_stopped");
    expect_at(1, STimeout, 16'd0, "mrst_timeout");
    expect_at(1, SAddr, 16'h000, "mrst_addr");
    tick(1);
    reset = 1'b0; mon_req = 1'b0;
    expect_at(2, SReset, 16'd0, "mrst_run");
    tick(2);

    // Entering START clears cpu_stopped.
    cpu_halted = 1'b1;
    expect_at(1, SStopped, 16'd1, "stopped_set2");
    tick(1);
    cpu_halted = 1'b0; mon_run = 1'b1; mon_start_addr = 9'h033;
    expect_at(1, SStopped, 16'd0, "stopped_clr");
    expect_at(1, SAddr, 16'h033, "stopped_run_addr");
    tick(1);
    mon_run = 1'b0;

    for (int w = 0; w < 100 && sb.size() > 0; w++) tick(1);
    while (sb.size() > 0) begin
      n_checks = n_checks + 1;
      n_fail   = n_fail + 1;
      $display("FAIL %s: expectation never checked", sb[0].name);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
